// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared states and widths for the RO PUF measurement controller
package ro_puf_pkg;

    localparam int MUX_SEL_W = 4;
    localparam int PAIR_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } state_e;

endpackage

// File: rtl/ro_puf_measure_ctrl_edge_counter.sv
// rtl/ro_puf_measure_ctrl_edge_counter.sv - ro_edge_counter: 2-flop synchronizer, rising-edge detect, saturating counter
module ro_edge_counter #(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_i,
    input  logic             clear_i,
    input  logic             count_en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic             sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_w;

    // History tracks at all times, so enabling the count never sees a stale edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_w = sync2_q & ~hist_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && rise_w && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_puf_measure_ctrl.sv
// rtl/ro_puf_measure_ctrl.sv - RO PUF challenge sequencer and count comparator; RO_PUF_DEBUG_CNT_EN adds count debug ports
module ro_puf_measure_ctrl
    import ro_puf_pkg::*;
#(
    parameter int NUM_BITS      = 8,
    parameter int CNT_W         = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 16
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [PAIR_W*NUM_BITS-1:0] challenge,
    input  logic                       ro_a_in,
    input  logic                       ro_b_in,
    output logic [MUX_SEL_W-1:0]       sel_a,
    output logic [MUX_SEL_W-1:0]       sel_b,
    output logic                       ro_en,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_BITS-1:0]        response,
    output logic [NUM_BITS-1:0]        tie
`ifdef RO_PUF_DEBUG_CNT_EN
    ,
    output logic [CNT_W-1:0]           dbg_cnt_a,
    output logic [CNT_W-1:0]           dbg_cnt_b,
    output logic                       dbg_valid
`endif
);

    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int TMR_W = 32;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BITS - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;
    logic [PAIR_W*NUM_BITS-1:0] chal_q, chal_d;
    logic [MUX_SEL_W-1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [NUM_BITS-1:0]        resp_q, resp_d, tie_q, tie_d;
    logic [PAIR_W-1:0]          pair_w [NUM_BITS];
    logic [CNT_W-1:0]           cnt_a_w, cnt_b_w;
    logic                       cnt_clear_w, cnt_en_w;

    for (genvar g = 0; g < NUM_BITS; g++) begin : g_pair
        assign pair_w[g] = chal_q[g*PAIR_W +: PAIR_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            chal_q  <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            resp_q  <= '0;
            tie_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            chal_q  <= chal_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
        end
    end

    // Mux selects are only updated on the way into SELECT, while the ROs are off.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        chal_d  = chal_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    resp_d  = '0;
                    tie_d   = '0;
                    idx_d   = '0;
                    sel_a_d = challenge[MUX_SEL_W-1:0];
                    sel_b_d = challenge[PAIR_W-1:MUX_SEL_W];
                    state_d = SELECT;
                end
            end
            SELECT: begin
                tmr_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = COUNT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            COUNT: begin
                if (tmr_q == WINDOW_LAST) begin
                    tmr_d   = '0;
                    state_d = COMPARE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            COMPARE: begin
                resp_d[idx_q] = cnt_a_w > cnt_b_w;
                tie_d[idx_q]  = (cnt_a_w == cnt_b_w) || (sel_a_q == sel_b_q);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    sel_a_d = pair_w[idx_d][MUX_SEL_W-1:0];
                    sel_b_d = pair_w[idx_d][PAIR_W-1:MUX_SEL_W];
                    state_d = SELECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnt_clear_w = (state_q == SELECT);
    assign cnt_en_w    = (state_q == COUNT);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ro_i       (ro_a_in),
        .clear_i    (cnt_clear_w),
        .count_en_i (cnt_en_w),
        .cnt_o      (cnt_a_w)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ro_i       (ro_b_in),
        .clear_i    (cnt_clear_w),
        .count_en_i (cnt_en_w),
        .cnt_o      (cnt_b_w)
    );

    assign sel_a    = sel_a_q;
    assign sel_b    = sel_b_q;
    assign ro_en    = (state_q == SETTLE) || (state_q == COUNT);
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign response = resp_q;
    assign tie      = tie_q;

`ifdef RO_PUF_DEBUG_CNT_EN
    logic [CNT_W-1:0] dbg_a_q, dbg_b_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_a_q <= '0;
            dbg_b_q <= '0;
        end else if (state_q == COMPARE) begin
            dbg_a_q <= cnt_a_w;
            dbg_b_q <= cnt_b_w;
        end
    end

    // Live counts during COMPARE so the data lines up with the valid pulse.
    assign dbg_valid = (state_q == COMPARE);
    assign dbg_cnt_a = (state_q == COMPARE) ? cnt_a_w : dbg_a_q;
    assign dbg_cnt_b = (state_q == COMPARE) ? cnt_b_w : dbg_b_q;
`endif

endmodule

// File: tb/tb_ro_puf_measure_ctrl.sv
// tb/tb_ro_puf_measure_ctrl.sv - self-checking bench for ro_puf_measure_ctrl with a 16-RO bank model
module tb_ro_puf_measure_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int          per [16];
    int          ro_half [16];
    logic [15:0] ro_vec;

    // Each RO is a free-running square wave of per[g] clk periods, offset off the clk edges.
    for (genvar g = 0; g < 16; g++) begin : g_ro
        logic ro = 1'b0;
        initial begin
            #(2 + g % 3);
            forever begin
                #(ro_half[g]);
                ro = ~ro;
            end
        end
        assign ro_vec[g] = ro;
    end

    logic        rst_n, rst_n8;
    logic        start1, start8, starts;
    logic [7:0]  ch1, chs;
    logic [63:0] ch8;
    logic [3:0]  sel_a1, sel_b1, sel_a8, sel_b8, sel_as, sel_bs;
    logic        ro_en1, ro_en8, ro_ens, busy1, busy8, busys, done1, done8, dones;
    logic [0:0]  resp1, tie1, resps, ties;
    logic [7:0]  resp8, tie8;
`ifdef RO_PUF_DEBUG_CNT_EN
    logic [15:0] dbga1, dbgb1, dbga8, dbgb8;
    logic [3:0]  dbgas, dbgbs;
    logic        dbgv1, dbgv8, dbgvs;
`endif

    ro_puf_measure_ctrl #(.NUM_BITS(1), .CNT_W(16), .WINDOW_CYCLES(1024), .SETTLE_CYCLES(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .challenge(ch1),
        .ro_a_in(ro_vec[sel_a1]), .ro_b_in(ro_vec[sel_b1]),
        .sel_a(sel_a1), .sel_b(sel_b1), .ro_en(ro_en1), .busy(busy1), .done(done1),
        .response(resp1), .tie(tie1)
`ifdef RO_PUF_DEBUG_CNT_EN
        , .dbg_cnt_a(dbga1), .dbg_cnt_b(dbgb1), .dbg_valid(dbgv1)
`endif
    );

    ro_puf_measure_ctrl #(.NUM_BITS(8), .CNT_W(16), .WINDOW_CYCLES(1024), .SETTLE_CYCLES(16)) u_d8 (
        .clk(clk), .rst_n(rst_n8), .start(start8), .challenge(ch8),
        .ro_a_in(ro_vec[sel_a8]), .ro_b_in(ro_vec[sel_b8]),
        .sel_a(sel_a8), .sel_b(sel_b8), .ro_en(ro_en8), .busy(busy8), .done(done8),
        .response(resp8), .tie(tie8)
`ifdef RO_PUF_DEBUG_CNT_EN
        , .dbg_cnt_a(dbga8), .dbg_cnt_b(dbgb8), .dbg_valid(dbgv8)
`endif
    );

    ro_puf_measure_ctrl #(.NUM_BITS(1), .CNT_W(4), .WINDOW_CYCLES(64), .SETTLE_CYCLES(16)) u_ds (
        .clk(clk), .rst_n(rst_n), .start(starts), .challenge(chs),
        .ro_a_in(ro_vec[sel_as]), .ro_b_in(ro_vec[sel_bs]),
        .sel_a(sel_as), .sel_b(sel_bs), .ro_en(ro_ens), .busy(busys), .done(dones),
        .response(resps), .tie(ties)
`ifdef RO_PUF_DEBUG_CNT_EN
        , .dbg_cnt_a(dbgas), .dbg_cnt_b(dbgbs), .dbg_valid(dbgvs)
`endif
    );

    typedef struct {
        logic [63:0] ch;
        logic [7:0]  resp;
        logic [7:0]  tie;
    } vec_t;

    vec_t        tbl [5];
    int          errors = 0;
    int          checks = 0;
    int          lat, seen;
    logic        r, t;
    logic [7:0]  r8, t8;
    logic [15:0] mdl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

`ifdef RO_PUF_DEBUG_CNT_EN
    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask
`endif

    task automatic set_per(input int i, input int p);
        per[i]     = p;
        ro_half[i] = 5 * p;
    endtask

    // Faster RO (shorter period) gives more edges; equal selects always tie at 0.
    function automatic logic [15:0] model(input logic [63:0] ch);
        logic [7:0] rr = '0;
        logic [7:0] tt = '0;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b     = 8'(ch >> (8 * i));
            tt[i] = (b[3:0] == b[7:4]);
            rr[i] = per[b[3:0]] < per[b[7:4]];
        end
        return {tt, rr};
    endfunction

    task automatic run1(input bit sat, input logic [7:0] ch, output logic ro, output logic to, output int l);
        @(negedge clk);
        if (sat) begin chs = ch; starts = 1'b1; end
        else begin ch1 = ch; start1 = 1'b1; end
        @(negedge clk);
        starts = 1'b0;
        start1 = 1'b0;
        l = 1;
        while (!(sat ? dones : done1) && l < 20000) begin
            @(negedge clk);
            l++;
        end
        ro = sat ? resps[0] : resp1[0];
        to = sat ? ties[0] : tie1[0];
    endtask

    task automatic run8(input logic [63:0] ch, input bit poke, output logic [7:0] ro, output logic [7:0] to, output int l);
        @(negedge clk);
        ch8    = ch;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        l = 1;
        while (!done8 && l < 20000) begin
            if (poke && l == 1)    chk("select_outputs", {sel_a8, sel_b8, ro_en8, busy8}, {4'h9, 4'h2, 1'b0, 1'b1});
            if (poke && l == 2)    chk("ro_en_settle", ro_en8, 1);
            if (poke && l == 1042) chk("compare_en_busy", {ro_en8, busy8}, 2'b01);
            start8 = poke && (l == 100 || l == 5000);
            if (start8) ch8 = {$urandom, $urandom};
            @(negedge clk);
            l++;
        end
        start8 = 1'b0;
        ro = resp8;
        to = tie8;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) set_per(i, i + 2);
        rst_n = 1'b0; rst_n8 = 1'b0;
        start1 = 1'b0; start8 = 1'b0; starts = 1'b0;
        ch1 = '0; ch8 = '0; chs = '0;
        repeat (3) @(negedge clk);
        chk("reset_d8", {sel_a8, sel_b8, ro_en8, busy8, done8, resp8, tie8}, 0);
        chk("reset_d1", {sel_a1, sel_b1, ro_en1, busy1, done1, resp1, tie1}, 0);
        rst_n = 1'b1; rst_n8 = 1'b1;

        tbl[0] = '{64'h9229_9229_9229_9229, 8'hAA, 8'h00};
        tbl[1] = '{64'h3377_1100_ffee_5544, 8'h00, 8'hFF};
        for (int k = 2; k < 5; k++) begin
            tbl[k].ch = {$urandom, $urandom};
            mdl = model(tbl[k].ch);
            tbl[k].tie  = mdl[15:8];
            tbl[k].resp = mdl[7:0];
        end

        set_per(1, 8); set_per(2, 10);
        run1(1'b0, 8'h21, r, t, lat);
        chk("a_fast_resp", r, 1);
        chk("a_fast_tie", t, 0);
        chk("a_fast_latency", lat, 1043);
`ifdef RO_PUF_DEBUG_CNT_EN
        chk_rng("dbg_cnt_a", int'(dbga1), 127, 129);
        chk_rng("dbg_cnt_b", int'(dbgb1), 101, 103);
`endif
        set_per(1, 10); set_per(2, 8);
        run1(1'b0, 8'h21, r, t, lat);
        chk("b_fast_resp", r, 0);
        chk("b_fast_tie", t, 0);
        run1(1'b0, 8'h33, r, t, lat);
        chk("same_sel_resp", r, 0);
        chk("same_sel_tie", t, 1);
        set_per(1, 3); set_per(2, 4);

        set_per(0, 2); set_per(1, 4);
        run1(1'b1, 8'h10, r, t, lat);
        chk("sat_resp", r, 0);
        chk("sat_tie", t, 1);
        chk("sat_latency", lat, 83);
`ifdef RO_PUF_DEBUG_CNT_EN
        chk("sat_dbg", {dbgas, dbgbs}, 8'hFF);
`endif
        set_per(1, 3);

        for (int k = 0; k < 5; k++) begin
            run8(tbl[k].ch, k == 0, r8, t8, lat);
            chk($sformatf("vec%0d_resp", k), r8, tbl[k].resp);
            chk($sformatf("vec%0d_tie", k), t8, tbl[k].tie);
            chk($sformatf("vec%0d_latency", k), lat, 8337);
            if (k == 0) begin
                start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                chk("start_on_done_ignored", {busy8, done8}, 0);
                chk("sel_held_idle", {sel_a8, sel_b8}, 8'h29);
                repeat (3) @(negedge clk);
                chk("resp_held_idle", {busy8, resp8}, 9'h0AA);
            end
        end

        @(negedge clk);
        ch8 = tbl[0].ch;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (lat < 3500) begin
            @(negedge clk);
            lat++;
        end
        chk("count_pair3_active", {busy8, ro_en8, sel_a8, sel_b8}, {1'b1, 1'b1, 4'h2, 4'h9});
        rst_n8 = 1'b0;
        @(negedge clk);
        rst_n8 = 1'b1;
        chk("reset_midrun", {sel_a8, sel_b8, ro_en8, busy8, done8, resp8, tie8}, 0);
        seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        run8(tbl[1].ch, 1'b0, r8, t8, lat);
        chk("after_reset_resp", r8, tbl[1].resp);
        chk("after_reset_tie", t8, tbl[1].tie);
        chk("after_reset_latency", lat, 8337);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_puf_measure_ctrl.md
Name: ro_puf_measure_ctrl

Overview:
- Sequences RO PUF response generation: drives the select lines of two 16:1 RO muxes (A and B) once per challenge pair.
- Enables the ring oscillators, counts the rising edges of each mux output over a fixed window, and compares the two counts to produce one response bit.
- Repeats for NUM_BITS pairs, then presents the assembled response word with a done pulse.
- Sits between the top-level challenge/response interface and the two mux16to1 instances.

Parameters:
NUM_BITS, 8, response bits per challenge; each bit uses one pair.
CNT_W, 16, edge counter width; counters saturate at all-ones.
WINDOW_CYCLES, 1024, clk cycles per counting window; must be ≥1.
SETTLE_CYCLES, 16, clk cycles the ROs run after enable before counting starts; must be ≥1.

Ports:
clk  in  1  system clock; only clock in the block.
rst_n  in  1  synchronous reset, active-low.
start  in  1  1-cycle request; sampled only in IDLE.
challenge  in  8*NUM_BITS  pair i = {sel_b = [8i+7:8i+4], sel_a = [8i+3:8i]}; latched on accepted start.
ro_a_in  in  1  mux A output, asynchronous to clk.
ro_b_in  in  1  mux B output, asynchronous to clk.
sel_a  out  4  select for mux A.
sel_b  out  4  select for mux B.
ro_en  out  1  ring-oscillator enable.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  1-cycle pulse when response is valid.
response  out  NUM_BITS  bit i = result of pair i; held until the next accepted start.
tie  out  NUM_BITS  bit i set when cnt_a == cnt_b or sel_a == sel_b for pair i.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; sel_a = 0, sel_b = 0, ro_en = 0, busy = 0, done = 0, response = 0, tie = 0, counters = 0, pair index = 0, synchronizers = 0.
- Reset mid-measurement aborts immediately with the same values; no done pulse is generated.
- States:
  - IDLE: start = 1 → latch challenge, clear response and tie, index = 0 → SELECT.
  - SELECT (1 cycle): ro_en = 0; sel_a/sel_b = pair[index]; clear both counters → SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): ro_en = 1. Synchronizers and edge-history flops run; no counting → COUNT.
  - COUNT (WINDOW_CYCLES cycles): ro_en = 1. Each synchronized rising edge increments its counter, saturating at 2^CNT_W-1 → COMPARE.
  - COMPARE (1 cycle): ro_en = 0. response[index] = (cnt_a > cnt_b). tie[index] = (cnt_a == cnt_b) or (sel_a == sel_b). If index == NUM_BITS-1 → DONE, else index+1 → SELECT.
  - DONE (1 cycle): done = 1, busy = 0 → IDLE.
- Latency: start accepted at cycle 0 → done asserted at cycle NUM_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+2)+1.
- Edge detection:
  - 2-flop synchronizer per RO input, then a history flop; an edge is sync = 1 and history = 0.
  - History flop tracks continuously from SETTLE onward, so no spurious edge at COUNT entry.
- sel_a/sel_b change only on entry to SELECT, when ro_en = 0. They hold their last value in IDLE.
- start while busy: ignored, with no queuing. start in the same cycle as done: ignored (state is DONE, not IDLE).
- sel_a == sel_b: measured normally; tie bit forced to 1; response bit is whatever the comparison yields (normally 0).
- Counter saturation: both counts pinned at max gives response 0, tie 1.

Optional Feature:
RO_PUF_DEBUG_CNT_EN:
- Defined: adds output ports dbg_cnt_a and dbg_cnt_b (CNT_W each) and dbg_valid (1-cycle pulse in COMPARE).
  - Counts are registered in COMPARE and held until the next COMPARE; reset value 0.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package ro_puf_pkg:
  - state enum (IDLE, SELECT, SETTLE, COUNT, COMPARE, DONE)
  - MUX_SEL_W = 4, PAIR_W = 8
- Sub-module ro_edge_counter: synchronizer + edge detect + saturating counter, with clear and count_en inputs. It is instantiated twice.

Test Plan:
- Bench ROs: ro_a period 8 clk, ro_b period 10 clk; WINDOW 1024, NUM_BITS 1, challenge 8'h21 → sel_a = 1, sel_b = 2; response = 1, tie = 0; dbg_cnt_a = 128±1, dbg_cnt_b = 102±1.
- Swap the RO periods, same challenge → response = 0, tie = 0.
- Challenge 8'h33 (sel_a == sel_b) with identical ROs → response = 0, tie = 1.
- NUM_BITS = 8, alternating faster RO per pair → response = 8'hAA. done occurs exactly at cycle 8*(16+1024+2)+1 = 8337. start pulses mid-run are ignored.
- CNT_W = 4, ro_a period 2 clk, ro_b period 4 clk, WINDOW 64 → both counters saturate at 15; response = 0, tie = 1.
- rst_n low during COUNT of pair 3 → next cycle all outputs are at reset values with no done. A fresh start then completes normally.
